operand_pair_sequencer: RTL and testbench

- Upstream stage of the 4-bit 2:1 mux in the ALU operand path.
- Collects 4-bit words from a valid/ready input stream into operand registers A and B.
- Presents A on the mux `d0` input and B on the mux `d1` input, then drives the mux select `s` over two consecutive issue beats, so A and then B are time-multiplexed onto the shared ALU input bus.
- Supports unary operations, which issue A only.

---
 rtl/operand_pair_sequencer_pkg.sv | 15 +
 rtl/operand_pair_sequencer.sv | 119 +++++++++++
 tb/tb_operand_pair_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand_pair_sequencer_pkg.sv
// Shared types for the ALU operand-pair sequencer and the mux-level top.
// Holds the FSM state encoding and the 2:1 mux select constants.
package operand_pair_sequencer_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        ISSUE_A = 2'd2,
        ISSUE_B = 2'd3
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/operand_pair_sequencer.sv
// Collects operand words A/B from a valid/ready stream and issues them as
// one (unary) or two (binary) select beats onto the ALU operand mux.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_data word, in_unary with A
//   mux_d0, mux_d1      operand A / B registers driving the mux inputs
//   mux_s               mux select (SEL_A / SEL_B)
//   out_valid/out_ready downstream beat handshake
//   out_first/out_last  beat position within the operation
//   pair_cnt            completed operations, wraps modulo 2^CW
module operand_pair_sequencer
    import operand_pair_sequencer_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_unary,
    output logic [W-1:0]  mux_d0,
    output logic [W-1:0]  mux_d1,
    output logic          mux_s,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic [CW-1:0] pair_cnt
);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           unary_q;
    logic [CW-1:0]  cnt_q;
    logic           load_a;
    logic           load_b;
    logic           cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            unary_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (load_a) begin
                a_q     <= in_data;
                unary_q <= in_unary;
                // Clear B so a unary op never shows a stale operand.
                if (in_unary) begin
                    b_q <= '0;
                end
            end
            if (load_b) begin
                b_q <= in_data;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_a    = 1'b0;
        load_b    = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            LOAD_A: begin
                if (in_valid) begin
                    load_a    = 1'b1;
                    state_nxt = in_unary ? ISSUE_A : LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    load_b    = 1'b1;
                    state_nxt = ISSUE_A;
                end
            end
            ISSUE_A: begin
                if (out_ready) begin
                    if (unary_q) begin
                        cnt_inc   = 1'b1;
                        state_nxt = LOAD_A;
                    end else begin
                        state_nxt = ISSUE_B;
                    end
                end
            end
            ISSUE_B: begin
                if (out_ready) begin
                    cnt_inc   = 1'b1;
                    state_nxt = LOAD_A;
                end
            end
            default: state_nxt = LOAD_A;
        endcase
    end

    // Moore outputs: decoded from registered state only.
    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == ISSUE_A) || (state == ISSUE_B);
    assign mux_s     = (state == ISSUE_B) ? SEL_B : SEL_A;
    assign out_first = (state == ISSUE_A);
    assign out_last  = ((state == ISSUE_A) && unary_q) ||
                       (state == ISSUE_B);
    assign mux_d0    = a_q;
    assign mux_d1    = b_q;
    assign pair_cnt  = cnt_q;

endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Scoreboard bench for operand_pair_sequencer (built with CW = 2).
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_operand_pair_sequencer;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_unary;
    logic [W-1:0]  mux_d0;
    logic [W-1:0]  mux_d1;
    logic          mux_s;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;
    logic [CW-1:0] pair_cnt;

    operand_pair_sequencer #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_unary  (in_unary),
        .mux_d0    (mux_d0),
        .mux_d1    (mux_d1),
        .mux_s     (mux_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .pair_cnt  (pair_cnt)
    );

    always #5 clk = ~clk;

    // Beat = {d0, d1, s, first, last, pair_cnt}
    typedef logic [W+W+3+CW-1:0] beat_t;

    beat_t         exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] cnt_model;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [W-1:0] d0,
                                 input logic [W-1:0] d1,
                                 input logic s, input logic f,
                                 input logic l, input logic [CW-1:0] c);
        return {d0, d1, s, f, l, c};
    endfunction

    // Monitor: every accepted beat must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat",
                    {17'd0, mux_d0, mux_d1, mux_s, out_first, out_last,
                     pair_cnt}, 32'd0);
                failures += 0;
            end else begin
                chk("beat",
                    32'({mux_d0, mux_d1, mux_s, out_first, out_last,
                         pair_cnt}),
                    32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic u);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) begin
            chk("send_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_unary = u;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_unary = 1'bx;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic u);
        if (u) begin
            exp_q.push_back(mk(a, '0, 1'b0, 1'b1, 1'b1, cnt_model));
        end else begin
            exp_q.push_back(mk(a, b, 1'b0, 1'b1, 1'b0, cnt_model));
            exp_q.push_back(mk(a, b, 1'b1, 1'b0, 1'b1, cnt_model));
        end
        cnt_model = cnt_model + CW'(1);
        send(a, u);
        if (!u) begin
            send(b, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((!in_ready || exp_q.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 100) begin
            chk("idle_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt_model = '0;
    endtask

    task automatic stall_chk(input logic s, input logic f, input logic l);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 4'hF;
            in_unary = 1'b0;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_bus", 32'({mux_d0, mux_d1, mux_s, out_first,
                                  out_last}),
                32'({4'h5, 4'h9, s, f, l}));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_unary  = 1'b0;
        out_ready = 1'b1;
        cnt_model = '0;

        // Reset state
        do_reset(2);
        chk("rst_d0", 32'(mux_d0), 32'd0);
        chk("rst_d1", 32'(mux_d1), 32'd0);
        chk("rst_s", 32'(mux_s), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pair_cnt", 32'(pair_cnt), 32'd0);
        chk("rst_first_last", 32'({out_first, out_last}), 32'd0);

        // Binary pair, no stalls; first beat right after B accepted
        op(4'h3, 4'hA, 1'b0);
        chk("bin_first_beat_now", 32'(out_valid), 32'd1);
        wait_idle();
        chk("bin_pair_cnt", 32'(pair_cnt), 32'd1);
        chk("bin_in_ready", 32'(in_ready), 32'd1);

        // Unary: single beat, B cleared
        op(4'h7, 4'h0, 1'b1);
        wait_idle();
        chk("un_pair_cnt", 32'(pair_cnt), 32'd2);

        // Backpressure with ignored input pulses
        out_ready = 1'b0;
        op(4'h5, 4'h9, 1'b0);
        stall_chk(1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        stall_chk(1'b1, 1'b0, 1'b1);
        out_ready = 1'b1;
        wait_idle();
        chk("bp_pair_cnt", 32'(pair_cnt), 32'd3);

        // Reset mid-operation: partial A discarded, no beat
        send(4'h2, 1'b0);
        chk("mid_in_loadb", 32'({in_ready, out_valid}), 32'b10);
        do_reset(1);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_d0_cleared", 32'(mux_d0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_no_beat", 32'(out_valid), 32'd0);
        op(4'h1, 4'h4, 1'b0);
        wait_idle();
        chk("mid_pair_cnt", 32'(pair_cnt), 32'd1);

        // Counter wrap with CW = 2: 1, 2, 3, 0, 1
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            logic [CW-1:0] want;
            want = CW'(i + 1);
            op(4'(i + 8), 4'h0, 1'b1);
            wait_idle();
            chk("wrap_pair_cnt", 32'(pair_cnt), 32'(want));
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
